// File: rtl/prod_sum_acc_dump.sv
// prod_sum_acc_dump: accumulates acc_len sum-of-products beats per frame in
// full precision, then converts the frame total to out_width bits (saturate
// or wrap) and presents it on a registered valid/ready output.
//
// Handshakes: a beat transfers on a rising edge where in_valid_i & in_ready_o,
// and a result transfers on a rising edge where out_valid_o & out_ready_i.
// Holding valid or ready high without its partner moves nothing. Payloads are
// stable while valid is held.
module prod_sum_acc_dump #(
  parameter int sum_width = 8,
  parameter int out_width = 12,
  parameter int acc_len   = 4,
  parameter bit sat_mode  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 tc_i,
  input  logic [sum_width-1:0] sum_in_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [out_width-1:0] acc_out_o,
  output logic                 ovf_o
);

  // Accumulator holds a whole frame without loss plus a sign bit.
  localparam int GROW = $clog2(acc_len);
  localparam int AW   = ((out_width > sum_width + GROW) ? out_width : sum_width + GROW) + 1;
  localparam int CW   = (acc_len > 1) ? $clog2(acc_len) : 1;

  // Range limits of the converted result, sign-extended to AW bits.
  localparam logic signed [AW-1:0] S_MAX = {{(AW-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [AW-1:0] S_MIN = {{(AW-out_width+1){1'b1}}, {(out_width-1){1'b0}}};
  localparam logic signed [AW-1:0] U_MAX = {{(AW-out_width){1'b0}}, {out_width{1'b1}}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   frame_tc_q, frame_tc_d;
  logic                   out_valid_q, out_valid_d;
  logic [out_width-1:0]   acc_out_q, acc_out_d;
  logic                   ovf_q, ovf_d;

  logic                   first, last, accept, dump, tc_eff;
  logic signed [AW-1:0]   sum_ext, total;
  logic [out_width-1:0]   conv_out;
  logic                   conv_ovf;

  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CW'(acc_len - 1));
  // Only the frame-completing beat waits on a held, untaken result.
  assign in_ready_o = !clr_i && (!last || !out_valid_q || out_ready_i);
  assign accept = in_valid_i && in_ready_o;
  assign dump   = accept && last;
  // The first beat of a frame uses the live tc; later beats use the latched one.
  assign tc_eff = first ? tc_i : frame_tc_q;

  // Extend the incoming beat and form the running frame total.
  always_comb begin
    if (tc_eff) sum_ext = {{(AW-sum_width){sum_in_i[sum_width-1]}}, sum_in_i};
    else        sum_ext = {{(AW-sum_width){1'b0}}, sum_in_i};
    total = first ? sum_ext : acc_q + sum_ext;
  end

  // Convert the frame total to out_width bits with range detection.
  always_comb begin
    conv_out = total[out_width-1:0];
    conv_ovf = 1'b0;
    if (tc_eff) begin
      if (total > S_MAX) begin
        conv_ovf = 1'b1;
        if (sat_mode) conv_out = S_MAX[out_width-1:0];
      end else if (total < S_MIN) begin
        conv_ovf = 1'b1;
        if (sat_mode) conv_out = S_MIN[out_width-1:0];
      end
    end else if (total > U_MAX) begin
      conv_ovf = 1'b1;
      if (sat_mode) conv_out = U_MAX[out_width-1:0];
    end
  end

  // Next-state for the frame counter, accumulator and output register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    frame_tc_d  = frame_tc_q;
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (first) frame_tc_d = tc_i;
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = total;
      end
    end
    if (dump) begin
      out_valid_d = 1'b1;
      acc_out_d   = conv_out;
      ovf_d       = conv_ovf;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial frame and pending result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      frame_tc_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      frame_tc_q  <= frame_tc_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign acc_out_o   = acc_out_q;
  assign ovf_o       = ovf_q;

endmodule
